// File: rtl/ofmap_drain_ctrl.sv
// Drains the output-feature-map FIFO into the GLB: packs popped elements into
// 32-bit words (byte or word mode) and issues one arbitrated write per word.
module ofmap_drain_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ofmap_fifo_reset_i,
  input  logic        ofmap_need_push_i,
  input  logic [31:0] ofmap_push_num_i,
  input  logic        ofmap_word_mode_i,
  input  logic [31:0] ofmap_fifo_base_addr_i,
  input  logic        ofmap_fifo_empty_i,
  input  logic [31:0] ofmap_fifo_pop_data_i,
  output logic        ofmap_fifo_pop_o,
  input  logic        fifo_glb_busy_i,
  output logic        ofmap_write_req_o,
  input  logic        ofmap_permit_write_i,
  output logic [31:0] ofmap_glb_write_addr_o,
  output logic [31:0] ofmap_glb_write_data_o,
  output logic [3:0]  ofmap_glb_web_o,
  output logic        ofmap_fifo_done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_WRITE = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] num_q, num_d;
  logic [31:0] base_q, base_d;
  logic        mode_q, mode_d;
  logic [31:0] elem_cnt_q, elem_cnt_d;
  logic [31:0] word_addr_q, word_addr_d;
  logic [31:0] pack_q, pack_d;
  logic [3:0]  mask_q, mask_d;

  logic [31:0] elem_addr;
  logic [1:0]  lane;
  logic        last_elem;

  // Address of the element at the FIFO head; wraps naturally at 32 bits.
  assign elem_addr = base_q + (mode_q ? {elem_cnt_q[29:0], 2'b00} : elem_cnt_q);
  assign lane      = elem_addr[1:0];
  assign last_elem = (elem_cnt_q == (num_q - 32'd1));

  assign ofmap_fifo_pop_o  = (state_q == S_POP) && !ofmap_fifo_empty_i && !fifo_glb_busy_i;
  assign ofmap_fifo_done_o = (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    base_d      = base_q;
    mode_d      = mode_q;
    elem_cnt_d  = elem_cnt_q;
    word_addr_d = word_addr_q;
    pack_d      = pack_q;
    mask_d      = mask_q;

    case (state_q)
      S_IDLE: begin
        if (ofmap_need_push_i && (ofmap_push_num_i != 32'd0)) begin
          num_d      = ofmap_push_num_i;
          base_d     = ofmap_fifo_base_addr_i;
          mode_d     = ofmap_word_mode_i;
          elem_cnt_d = 32'd0;
          pack_d     = 32'd0;
          mask_d     = 4'd0;
          state_d    = S_POP;
        end
      end

      S_POP: begin
        if (fifo_glb_busy_i) begin
          state_d = S_WAIT;
        end else if (!ofmap_fifo_empty_i) begin
          elem_cnt_d = elem_cnt_q + 32'd1;
          if (mode_q) begin
            pack_d      = ofmap_fifo_pop_data_i;
            mask_d      = 4'hF;
            word_addr_d = elem_addr;
            state_d     = S_WRITE;
          end else begin
            // The first byte landing in an empty buffer fixes the word address.
            if (mask_q == 4'd0) begin
              word_addr_d = elem_addr;
            end
            pack_d[{lane, 3'b000} +: 8] = ofmap_fifo_pop_data_i[7:0];
            mask_d[lane]                = 1'b1;
            if ((lane == 2'd3) || last_elem) begin
              state_d = S_WRITE;
            end
          end
        end
      end

      S_WAIT: begin
        if (!fifo_glb_busy_i) begin
          state_d = S_POP;
        end
      end

      S_WRITE: begin
        if (ofmap_permit_write_i) begin
          pack_d  = 32'd0;
          mask_d  = 4'd0;
          state_d = (elem_cnt_q == num_q) ? S_IDLE : S_POP;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || ofmap_fifo_reset_i) begin
      state_q     <= S_IDLE;
      num_q       <= 32'd0;
      base_q      <= 32'd0;
      mode_q      <= 1'b0;
      elem_cnt_q  <= 32'd0;
      word_addr_q <= 32'd0;
      pack_q      <= 32'd0;
      mask_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      base_q      <= base_d;
      mode_q      <= mode_d;
      elem_cnt_q  <= elem_cnt_d;
      word_addr_q <= word_addr_d;
      pack_q      <= pack_d;
      mask_q      <= mask_d;
    end
  end

  // Write-side outputs come straight from registers, so they hold until permit.
  assign ofmap_write_req_o      = (state_q == S_WRITE);
  assign ofmap_glb_write_addr_o = ofmap_write_req_o ? {word_addr_q[31:2], 2'b00} : 32'd0;
  assign ofmap_glb_write_data_o = ofmap_write_req_o ? pack_q : 32'd0;
  assign ofmap_glb_web_o        = ofmap_write_req_o ? mask_q : 4'd0;

endmodule
